ahb_lite_sram_slave: RTL and testbench

- Parametrised AHB-Lite memory slave; successor to the fixed 32-bit, 1K-word slave memory.
- Adds configurable data/address width, byte/halfword writes via HSIZE, and a parametrised read-only window.
- Adds a spec-compliant two-cycle ERROR response, HREADY-in/HREADYOUT split and write-to-read forwarding.
- Sits behind the AHB-Lite decoder/mux as a leaf slave in the UVM test environment.

---
 rtl/ahb_lite_sram_slave.sv | 187 ++++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   Parametrised AHB-Lite SRAM slave. Byte/halfword/word(/dword) writes via
//   HSIZE, a read-only byte window, a two-cycle ERROR response, an HREADY
//   input separate from HREADYOUT, and write-to-read forwarding for
//   back-to-back transfers.
//
//   Optional feature macro: AHB_MEM_WAIT_EN
//     defined   : every non-error transfer inserts WAIT_STATES cycles of
//                 HREADYOUT=0 before its data cycle.
//     undefined : all transfers are zero-wait and WAIT_STATES is ignored.
//
//   Ports
//     HCLK, HRESETn        clock, asynchronous active-low reset
//     HSEL, HADDR, HTRANS  address phase: select, byte address, transfer type
//     HWRITE, HSIZE        direction, transfer size (log2 bytes)
//     HWDATA               write data (data phase)
//     HREADY               bus-level ready (address phase accepted when high)
//     HREADYOUT, HRESP     slave ready, 0=OKAY / 1=ERROR
//     HRDATA               read data, holds outside read data phases

// One byte lane: decides whether the lane is covered by the transfer and
// picks forwarded write data over array data for the read path.
module ahb_lite_sram_slave_lane #(
  parameter int LANE = 0,
  parameter int LB   = 2
) (
  input  logic [2:0]    size,
  input  logic [LB-1:0] ofs,
  input  logic          fwd,
  input  logic [7:0]    wbyte,
  input  logic [7:0]    mbyte,
  output logic          sel,
  output logic [7:0]    rbyte
);
  // Lane is covered when it sits in the same aligned 2**size block as ofs.
  assign sel   = (LANE >> size) == (int'(ofs) >> size);
  assign rbyte = fwd ? wbyte : mbyte;
endmodule

module ahb_lite_sram_slave #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RO_START    = 'h000,
  parameter logic [ADDR_WIDTH-1:0] RO_END      = 'h00F,
  parameter int                    WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int WAW   = ADDR_WIDTH - LB;
  localparam int DEPTH = 1 << WAW;

`ifdef AHB_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam logic [3:0]            WS      = WAIT_EN ? 4'(WAIT_STATES) : 4'd0;
  localparam logic [ADDR_WIDTH-1:0] RO_SPAN = RO_END - RO_START;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

  typedef struct packed {
    logic [WAW-1:0] word;
    logic           write;
    logic [NB-1:0]  mask;
  } req_t;

  state_t state, state_nx, acc_nx;
  req_t   req_q;
  logic [3:0] wcnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  take, err, in_ro, misal, big, fwd;
  logic [2:0]            amask;
  logic [ADDR_WIDTH-1:0] ro_ofs;
  logic [WAW-1:0]        acc_word;
  logic [NB-1:0]         acc_mask;
  logic [DATA_WIDTH-1:0] rd_word, rd_fwd;
  logic                  unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // ---------------- address-phase decode ----------------
  // HREADYOUT gating keeps a stray HREADY from slipping an accept into
  // WAIT/ERR1, where this slave is the one stalling the bus.
  assign take     = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign acc_word = HADDR[ADDR_WIDTH-1:LB];

  // Unsigned offset trick: one compare covers [RO_START, RO_END].
  assign ro_ofs = HADDR - RO_START;
  assign in_ro  = ro_ofs <= RO_SPAN;
  assign big    = HSIZE > 3'(LB);

  always_comb begin
    case (HSIZE)
      3'd0:    amask = 3'b000;
      3'd1:    amask = 3'b001;
      3'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end
  assign misal = |(HADDR[2:0] & amask);
  assign err   = (HWRITE & in_ro) | big | misal;

  // Read accepted while a write to the same word is in its data cycle:
  // the array still holds old bytes, so splice in HWDATA on the written lanes.
  assign fwd     = (state == S_DATA) & req_q.write & (req_q.word == acc_word);
  assign rd_word = mem[acc_word];

  for (genvar g = 0; g < NB; g++) begin : g_lane
    ahb_lite_sram_slave_lane #(.LANE(g), .LB(LB)) u_lane (
      .size  (HSIZE),
      .ofs   (HADDR[LB-1:0]),
      .fwd   (fwd & req_q.mask[g]),
      .wbyte (HWDATA[g*8 +: 8]),
      .mbyte (rd_word[g*8 +: 8]),
      .sel   (acc_mask[g]),
      .rbyte (rd_fwd[g*8 +: 8])
    );
  end

  // ---------------- FSM ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    acc_nx   = err ? S_ERR1 : ((WS != 4'd0) ? S_WAIT : S_DATA);
    state_nx = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: state_nx = take ? acc_nx : S_IDLE;
      S_WAIT:                 if (wcnt == 4'd1) state_nx = S_DATA;
      S_ERR1:                 state_nx = S_ERR2;
      default:                state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // ---------------- request / read data ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_q  <= '0;
      wcnt   <= '0;
      HRDATA <= '0;
    end else if (take) begin
      req_q <= '{word: acc_word, write: HWRITE & ~err, mask: acc_mask};
      wcnt  <= WS;
      if (!err && !HWRITE && WS == 4'd0) HRDATA <= rd_fwd;
    end else if (state == S_WAIT) begin
      wcnt <= wcnt - 4'd1;
      // Preceding write has already committed, so the plain array read is current.
      if (wcnt == 4'd1 && !req_q.write) HRDATA <= mem[req_q.word];
    end
  end

  // ---------------- array write ----------------
  // Reset forces state to IDLE asynchronously, which drops a pending write.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && req_q.write)
      for (int b = 0; b < NB; b++)
        if (req_q.mask[b]) mem[req_q.word][b*8 +: 8] <= HWDATA[b*8 +: 8];
  end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench for ahb_lite_sram_slave (32-bit, 12-bit address).
// Directed table, hand-written pipelined/reset sequences, then random
// transfers checked against a byte-array reference model.
module tb_ahb_lite_sram_slave;
`ifdef AHB_MEM_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, hr_gate;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA, HRDATA;

  // Single-slave bus: HREADY follows HREADYOUT, gate lets the bench stall it.
  assign HREADY = HREADYOUT & hr_gate;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RO_START(12'h000),
                        .RO_END(12'h00F), .WAIT_STATES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA));

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model: byte memory ----------------
  logic [7:0] mm [4096];
  bit         kn [4096];

  function automatic bit m_err(input logic w, input logic [11:0] a, input logic [2:0] sz);
    int ai = int'(a);
    if (sz > 3'd2) return 1'b1;
    if ((ai % (1 << sz)) != 0) return 1'b1;
    if (w && ai <= 'h00F) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    int base = int'(a) - (int'(a) % n);
    for (int i = 0; i < n; i++) begin
      mm[base+i] = wd[8*((base+i) % 4) +: 8];
      kn[base+i] = 1'b1;
    end
  endtask

  task automatic m_word(input logic [11:0] a, output logic [31:0] d, output logic [31:0] mk);
    int base = int'(a) - (int'(a) % 4);
    d = '0; mk = '0;
    for (int i = 0; i < 4; i++) begin
      d[8*i +: 8]  = mm[base+i];
      mk[8*i +: 8] = kn[base+i] ? 8'hFF : 8'h00;
    end
  endtask

  // ---------------- bus helpers ----------------
  // Sample at negedge until HREADYOUT=1; report stall count and HRESP.
  task automatic wait_rdy(output int lows, output logic r_first, output logic r_fin);
    lows = 0; r_first = 1'b0; r_fin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (i == 0) r_first = HRESP;
      if (HREADYOUT) begin
        r_fin = HRESP;
        return;
      end
      lows++;
    end
    checks++; errors++;
    $display("FAIL wait_rdy: HREADYOUT stuck at 0 for 40 cycles, required 1");
  endtask

  // One isolated NONSEQ transfer; call and return at posedge+1.
  task automatic xfer(input logic w, input logic [11:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output int lows, output logic rf,
                      output logic rl, output logic [31:0] rd);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    wait_rdy(lows, rf, rl);
    rd = HRDATA;
    @(posedge HCLK); #1;
  endtask

  // Transfer + checks against the model (or an explicit expected read value).
  task automatic run(input string nm, input logic w, input logic [11:0] a,
                     input logic [2:0] sz, input logic [31:0] wd, input bit use_exp,
                     input logic [31:0] exp, output logic [31:0] rd);
    int lows; logic rf, rl, e; logic [31:0] ed, mk;
    e = m_err(w, a, sz);
    xfer(w, a, sz, wd, lows, rf, rl, rd);
    chk({nm, " stall"}, lows, e ? 1 : WS);
    chk({nm, " resp1"}, {31'd0, rf}, {31'd0, e});
    chk({nm, " resp"},  {31'd0, rl}, {31'd0, e});
    if (!e && w) m_write(a, sz, wd);
    if (!e && !w) begin
      m_word(a, ed, mk);
      if (use_exp)       chk({nm, " rdata"}, rd, exp);
      else if (mk != 0)  chk({nm, " rdata"}, rd & mk, ed & mk);
    end
  endtask

  // Write followed by a read with no gap (read address phase overlaps write data).
  task automatic pipe(input string nm, input logic [11:0] wa, input logic [2:0] wsz,
                      input logic [31:0] wd, input logic [11:0] ra);
    int lows; logic rf, rl; logic [31:0] ed, mk;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = wa; HWRITE = 1'b1; HSIZE = wsz;
    @(posedge HCLK); #1;
    HADDR = ra; HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = wd;
    wait_rdy(lows, rf, rl);
    chk({nm, " w stall"}, lows, WS);
    chk({nm, " w resp"}, {31'd0, rl}, 32'd0);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    m_write(wa, wsz, wd);
    m_word(ra, ed, mk);
    wait_rdy(lows, rf, rl);
    chk({nm, " r stall"}, lows, WS);
    chk({nm, " r resp"}, {31'd0, rl}, 32'd0);
    chk({nm, " fwd rdata"}, HRDATA & mk, ed & mk);
    @(posedge HCLK); #1;
  endtask

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [18];
  logic [31:0] rd, v0, ed, mk;
  int          lows;
  logic        rf, rl;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 12'h100, 3'd2, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 12'h100, 3'd2, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 12'h101, 3'd0, 32'h00005A00, 32'h0};
    tbl[3]  = '{1'b0, 12'h100, 3'd2, 32'h0,        32'hDEAD5AEF};
    tbl[4]  = '{1'b1, 12'h103, 3'd1, 32'hFFFFFFFF, 32'h0};        // misaligned half
    tbl[5]  = '{1'b1, 12'h200, 3'd3, 32'hFFFFFFFF, 32'h0};        // dword on 32-bit
    tbl[6]  = '{1'b0, 12'h100, 3'd2, 32'h0,        32'hDEAD5AEF};
    tbl[7]  = '{1'b1, 12'h102, 3'd1, 32'hCAFE0000, 32'h0};
    tbl[8]  = '{1'b0, 12'h103, 3'd0, 32'h0,        32'hCAFE5AEF};
    tbl[9]  = '{1'b1, 12'h104, 3'd2, 32'h01020304, 32'h0};
    tbl[10] = '{1'b1, 12'h107, 3'd0, 32'hAB000000, 32'h0};
    tbl[11] = '{1'b0, 12'h104, 3'd2, 32'h0,        32'hAB020304};
    tbl[12] = '{1'b1, 12'h106, 3'd2, 32'h0,        32'h0};        // misaligned word
    tbl[13] = '{1'b0, 12'h102, 3'd2, 32'h0,        32'h0};        // misaligned read
    tbl[14] = '{1'b1, 12'h00F, 3'd0, 32'h0,        32'h0};        // RO upper edge
    tbl[15] = '{1'b1, 12'h010, 3'd2, 32'h55AA55AA, 32'h0};        // just past RO
    tbl[16] = '{1'b0, 12'h010, 3'd2, 32'h0,        32'h55AA55AA};
    tbl[17] = '{1'b1, 12'h00C, 3'd1, 32'h0,        32'h0};        // RO half

    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = '0; hr_gate = 1'b1;

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    chk("reset HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
    chk("reset HRESP",     {31'd0, HRESP},     32'd0);
    chk("reset HRDATA",    HRDATA,             32'd0);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Directed table
    for (int i = 0; i < 18; i++)
      run($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd,
          !tbl[i].w, tbl[i].exp, rd);

    // Read-only window: write rejected, contents and HRDATA preserved
    xfer(1'b0, 12'h004, 3'd2, 32'h0, lows, rf, rl, v0);
    chk("ro pre-read resp", {31'd0, rl}, 32'd0);
    run("ro write", 1'b1, 12'h004, 3'd2, 32'h12345678, 1'b0, 32'h0, rd);
    chk("ro err HRDATA hold", rd, v0);
    xfer(1'b0, 12'h004, 3'd2, 32'h0, lows, rf, rl, rd);
    chk("ro post-read resp", {31'd0, rl}, 32'd0);
    chk("ro post-read data", rd, v0);

    // Back-to-back write -> read forwarding
    pipe("fwd word", 12'h200, 3'd2, 32'h11223344, 12'h200);
    pipe("fwd byte", 12'h201, 3'd0, 32'h00007700, 12'h200);
    pipe("fwd half", 12'h202, 3'd1, 32'hBEEF0000, 12'h200);

    // HRDATA holds across a later write
    run("hold wr", 1'b1, 12'h208, 3'd2, 32'h0BADF00D, 1'b0, 32'h0, rd);
    m_word(12'h200, ed, mk);
    chk("HRDATA hold", HRDATA, ed);

    // No accept with HREADY low, on BUSY, or with HSEL low
    run("prep 300", 1'b1, 12'h300, 3'd2, 32'h5555AAAA, 1'b0, 32'h0, rd);
    HWDATA = 32'hFFFFFFFF; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 12'h300;
    hr_gate = 1'b0; HSEL = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    hr_gate = 1'b1; HTRANS = 2'b01;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("no-accept HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
    chk("no-accept HRESP",     {31'd0, HRESP},     32'd0);
    @(posedge HCLK); #1;
    run("no-accept read", 1'b0, 12'h300, 3'd2, 32'h0, 1'b0, 32'h0, rd);

    // Reset in the middle of a write: response clears, write dropped
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 12'h300; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h99999999;
    #1 HRESETn = 1'b0;
    #1;
    chk("midreset HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
    chk("midreset HRESP",     {31'd0, HRESP},     32'd0);
    chk("midreset HRDATA",    HRDATA,             32'd0);
    @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    run("midreset read", 1'b0, 12'h300, 3'd2, 32'h0, 1'b0, 32'h0, rd);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic        w;
      logic [11:0] a;
      logic [2:0]  sz;
      int          r;
      w  = 1'($urandom % 2);
      a  = 12'($urandom_range(0, 'h3F));
      r  = int'($urandom % 8);
      sz = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 7) ? 3'd2 : 3'd3;
      if ($urandom % 4 == 0) begin
        if (sz == 3'd3) sz = 3'd2;
        a = 12'($urandom_range('h10, 'h3F));
        a = a - 12'(int'(a) % (1 << sz));
        pipe("rnd pipe", a, sz, $urandom, a & 12'hFFC);
      end else begin
        run("rnd", w, a, sz, $urandom, 1'b0, 32'h0, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
